mandel_pixel_writer: RTL and testbench

Downstream consumer of the Mandelbrot rendering engine's output port. It pulls iteration counts in bursts using the engine's `ready`/`send_data` handshake, buffers them in a small FIFO and maps each count to a 24-bit RGB pixel. It then writes the pixels in raster order to a frame-buffer write port that can apply backpressure, and closes each frame by pulsing `clear_frame` back to the engine.

---
 rtl/mandel_pixel_writer_if.sv | 25 ++
 rtl/mandel_pixel_writer.sv | 257 +++++++++++++++++++++++++
 tb/tb_mandel_pixel_writer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_pixel_writer_if.sv
// Frame-buffer write port used by mandel_pixel_writer.
// master: pixel writer drives the write request and holds it while mem_busy is high.
// slave : frame buffer samples the write and applies backpressure through mem_busy.
interface mandel_pixel_writer_if #(
  parameter int ADDR_W = 21
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              mem_busy;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_busy
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_busy
  );
endinterface

// File: rtl/mandel_pixel_writer.sv
// mandel_pixel_writer: pulls iteration counts from the Mandelbrot engine in
// bursts, colours them, buffers them in a small FIFO and writes them in raster
// order to a frame buffer that can stall. Each completed frame is acknowledged
// to the engine with a clear_frame pulse.
// Optional build macro: MANDEL_PALETTE_EN selects the colour palette; without
// it the output is grayscale.
module mandel_pixel_writer #(
  parameter int SET_SIZE   = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_ITER   = 255,
  parameter int ADDR_W     = 21
) (
  input  logic                  CLK,
  input  logic                  SYS_RESET_N,
  input  logic                  render_reset,
  input  logic                  ready,
  output logic                  send_data,
  input  logic [31:0]           data,
  input  logic                  frame_ready,
  output logic                  clear_frame,
  input  logic [20:0]           total_pixels,
  mandel_pixel_writer_if.master fb,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int FW    = CNT_W + 1;
  localparam int K_W   = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [FW-1:0]    DEPTH_F  = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0]    SET_F    = FW'(SET_SIZE);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(SET_SIZE - 1);
  localparam logic [31:0]      MAX_IT_C = 32'(MAX_ITER);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV
  } state_t;

  // Request FSM
  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             send_data_q, send_data_d;

  // Pixel FIFO
  logic [23:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Output register and frame bookkeeping
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [23:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              pend_q, pend_d;

  logic          accept;
  logic          out_free;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          last_pix;
  logic [FW-1:0] free_after_pop;
  logic [23:0]   pixel_in;

  // Counts at or above MAX_ITER are inside the set and render black.
  function automatic logic [23:0] map_pixel(input logic [31:0] cnt);
    logic [7:0] g;
    g = (cnt > 32'd255) ? 8'hFF : cnt[7:0];
    if (cnt >= MAX_IT_C) begin
      return 24'h000000;
    end
`ifdef MANDEL_PALETTE_EN
    return {g, g[6:0], 1'b0, g[5:0], 2'b00};
`else
    return {g, g, g};
`endif
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept     = mem_we_q && !fb.mem_busy;
  assign out_free   = !mem_we_q || accept;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = !fifo_empty && out_free;
  assign push_req   = (state_q == ST_RECV);
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign last_pix   = (pix_cnt_q == ADDR_W'(total_pixels - 21'd1));
  assign pixel_in   = map_pixel(data);
  // Free slots are judged after this cycle's pop so a draining FIFO can request early.
  assign free_after_pop = DEPTH_F - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};

  // Request FSM state register.
  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      send_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      send_data_q <= send_data_d;
    end
  end

  // Request FSM next state: one send_data pulse, then SET_SIZE sampled words.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    send_data_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready && (free_after_pop >= SET_F)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_RECV;
        k_d     = '0;
      end
      ST_RECV: begin
        if (k_q == K_LAST) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (render_reset) begin
      state_d = ST_IDLE;
      k_d     = '0;
    end
    send_data_d = (state_d == ST_REQ);
  end

  // FIFO storage: write-only array, no reset needed since count_q gates reads.
  always_ff @(posedge CLK) begin
    if (push && !render_reset) begin
      fifo_mem[wr_ptr_q] <= pixel_in;
    end
  end

  // Datapath next state: FIFO pointers, output register, pixel counter, frame flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    pend_d       = pend_q;

    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (accept) begin
      mem_we_d = 1'b0;
      if (last_pix) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
      end
    end
    // Reloading on the accept edge keeps one write per cycle.
    if (pop) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = pix_cnt_d;
      mem_wdata_d = fifo_mem[rd_ptr_q];
    end

    if (clear_frame) begin
      pend_d = 1'b0;
    end else if (frame_done_q) begin
      pend_d = 1'b1;
    end

    if (render_reset) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      pix_cnt_d    = '0;
      frame_done_d = 1'b0;
      pend_d       = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
    end
  end

  // The acknowledge fires the moment the engine reports its frame complete.
  assign clear_frame  = frame_ready && (frame_done_q || pend_q);
  assign send_data    = send_data_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;
  assign fb.mem_we    = mem_we_q;
  assign fb.mem_addr  = mem_addr_q;
  assign fb.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Testbench for mandel_pixel_writer: a small engine model answers send_data
// with queued words, a monitor logs accepted writes and output pulses.
`timescale 1ns/1ps
module tb_mandel_pixel_writer;
  localparam int SET_SIZE   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int MAX_ITER   = 255;
  localparam int ADDR_W     = 21;

`ifdef MANDEL_PALETTE_EN
  localparam logic [23:0] EXP_A [4] = '{24'h050A14, 24'hC89020, 24'hFEFCF8, 24'h000000};
  localparam logic [23:0] EXP_B [4] = '{24'h010204, 24'h020408, 24'h03060C, 24'h000000};
`else
  localparam logic [23:0] EXP_A [4] = '{24'h050505, 24'hC8C8C8, 24'hFEFEFE, 24'h000000};
  localparam logic [23:0] EXP_B [4] = '{24'h010101, 24'h020202, 24'h030303, 24'h000000};
`endif

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b1;
  logic        render_reset = 1'b0;
  logic        ready        = 1'b0;
  logic        frame_ready  = 1'b0;
  logic [31:0] data         = 32'd0;
  logic [20:0] total_pixels = 21'd16;
  logic        send_data;
  logic        clear_frame;
  logic        frame_done;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mandel_pixel_writer_if #(.ADDR_W(ADDR_W)) fb_if();

  mandel_pixel_writer #(
    .SET_SIZE  (SET_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_ITER  (MAX_ITER),
    .ADDR_W    (ADDR_W)
  ) dut (
    .CLK         (clk),
    .SYS_RESET_N (rst_n),
    .render_reset(render_reset),
    .ready       (ready),
    .send_data   (send_data),
    .data        (data),
    .frame_ready (frame_ready),
    .clear_frame (clear_frame),
    .total_pixels(total_pixels),
    .fb          (fb_if),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Engine model: a send_data pulse is answered with SET_SIZE words, one per edge.
  logic [31:0] eng_words [$];
  initial begin : engine
    forever begin
      @(negedge clk);
      if (send_data === 1'b1) begin
        ready = 1'b0;
        for (int k = 0; k < SET_SIZE; k++) begin
          @(posedge clk);
          #1;
          if (eng_words.size() > 0) data = eng_words.pop_front();
          else data = 32'd0;
        end
      end
      ready = (eng_words.size() >= SET_SIZE);
    end
  end

  // Monitor: accepted writes and output pulses, sampled mid-cycle.
  int          wr_addr [$];
  logic [23:0] wr_data [$];
  int          wr_cyc  [$];
  int   sd_pulses = 0, sd_last_cyc = -10, sd_consec = 0;
  int   fd_pulses = 0, fd_last_cyc = -1;
  int   cf_pulses = 0, cf_last_cyc = -1;
  int   we_rise_cyc = -1;
  logic sd_prev = 1'b0, we_prev = 1'b0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fb_if.mem_we === 1'b1 && fb_if.mem_busy === 1'b0) begin
          wr_addr.push_back(int'(fb_if.mem_addr));
          wr_data.push_back(fb_if.mem_wdata);
          wr_cyc.push_back(cyc);
        end
        if (send_data === 1'b1) begin
          sd_pulses++;
          sd_last_cyc = cyc;
          if (sd_prev) sd_consec++;
        end
        if (frame_done === 1'b1) begin
          fd_pulses++;
          fd_last_cyc = cyc;
        end
        if (clear_frame === 1'b1) begin
          cf_pulses++;
          cf_last_cyc = cyc;
        end
        if (fb_if.mem_we === 1'b1 && !we_prev) we_rise_cyc = cyc;
      end
      sd_prev = (send_data === 1'b1);
      we_prev = (fb_if.mem_we === 1'b1);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    eng_words.push_back(w0);
    eng_words.push_back(w1);
    eng_words.push_back(w2);
    eng_words.push_back(w3);
  endtask

  task automatic wait_writes(input int n, input string name);
    int t = 0;
    while (wr_addr.size() < n && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (wr_addr.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: writes=%0d required=%0d", name, wr_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    fb_if.mem_busy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (send_data !== 1'b0) begin errors++; $display("FAIL reset_send_data: got %b want 0", send_data); end
    checks++; if (clear_frame !== 1'b0) begin errors++; $display("FAIL reset_clear_frame: got %b want 0", clear_frame); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (fb_if.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", fb_if.mem_we); end
    checks++; if (fb_if.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", fb_if.mem_addr); end
    checks++; if (fb_if.mem_wdata !== 24'h0) begin errors++; $display("FAIL reset_mem_wdata: got %06h want 000000", fb_if.mem_wdata); end
    rst_n = 1'b1;
    tick(2);
    $display("test_reset: done");
  endtask

  task automatic test_single_burst();
    int base = wr_addr.size();
    int sd0  = sd_pulses;
    feed(32'd5, 32'd200, 32'd254, 32'd300);
    wait_writes(base + 4, "single_burst");
    checks++;
    if (sd_pulses - sd0 !== 1) begin errors++; $display("FAIL single_burst_pulses: got %0d want 1", sd_pulses - sd0); end
    checks++;
    if (we_rise_cyc - sd_last_cyc !== 3) begin errors++; $display("FAIL single_burst_latency: got %0d want 3", we_rise_cyc - sd_last_cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[base+i] !== i || wr_data[base+i] !== EXP_A[i]) begin
        errors++;
        $display("FAIL single_burst_pix%0d: got addr=%0d data=%06h want addr=%0d data=%06h",
                 i, wr_addr[base+i], wr_data[base+i], i, EXP_A[i]);
      end
      $display("single_burst: addr=%0d data=%06h", wr_addr[base+i], wr_data[base+i]);
    end
    tick(2);
    checks++;
    if (fb_if.mem_we !== 1'b0) begin errors++; $display("FAIL single_burst_idle_we: got %b want 0", fb_if.mem_we); end
  endtask

  task automatic test_burst_order();
    int base = wr_addr.size();
    feed(32'd1, 32'd2, 32'd3, 32'd255);
    wait_writes(base + 4, "burst_order");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[base+i] !== 4 + i || wr_data[base+i] !== EXP_B[i] || wr_cyc[base+i] !== wr_cyc[base] + i) begin
        errors++;
        $display("FAIL burst_order_pix%0d: got addr=%0d data=%06h cyc+%0d want addr=%0d data=%06h cyc+%0d",
                 i, wr_addr[base+i], wr_data[base+i], wr_cyc[base+i] - wr_cyc[base], 4 + i, EXP_B[i], i);
      end
      $display("burst_order: addr=%0d data=%06h", wr_addr[base+i], wr_data[base+i]);
    end
  endtask

  task automatic test_frame_wrap();
    int base = wr_addr.size();
    int fd0  = fd_pulses;
    int cf0  = cf_pulses;
    logic [23:0] exp_d;
    frame_ready = 1'b1;
    feed(32'd5, 32'd255, 32'd5, 32'd255);
    feed(32'd5, 32'd255, 32'd5, 32'd255);
    wait_writes(base + 8, "frame_wrap");
    tick(3);
    for (int i = 0; i < 8; i++) begin
      exp_d = (i % 2 == 0) ? EXP_A[0] : 24'h000000;
      checks++;
      if (wr_addr[base+i] !== 8 + i || wr_data[base+i] !== exp_d) begin
        errors++;
        $display("FAIL frame_wrap_pix%0d: got addr=%0d data=%06h want addr=%0d data=%06h",
                 i, wr_addr[base+i], wr_data[base+i], 8 + i, exp_d);
      end
    end
    checks++;
    if (fd_pulses - fd0 !== 1 || fd_last_cyc !== wr_cyc[base+7] + 1) begin
      errors++;
      $display("FAIL frame_wrap_done: got pulses=%0d at cyc %0d want 1 at cyc %0d",
               fd_pulses - fd0, fd_last_cyc, wr_cyc[base+7] + 1);
    end
    checks++;
    if (cf_pulses - cf0 !== 1 || cf_last_cyc !== fd_last_cyc) begin
      errors++;
      $display("FAIL frame_wrap_clear: got pulses=%0d at cyc %0d want 1 at cyc %0d",
               cf_pulses - cf0, cf_last_cyc, fd_last_cyc);
    end
    $display("frame_wrap: frame_done cyc=%0d clear_frame cyc=%0d", fd_last_cyc, cf_last_cyc);
  endtask

  task automatic test_backpressure();
    int base = wr_addr.size();
    int sd0  = sd_pulses;
    int unstable = 0;
    logic held = 1'b0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [23:0] h_data = '0;
    fb_if.mem_busy = 1'b1;
    feed(32'd1, 32'd2, 32'd3, 32'd255);
    feed(32'd1, 32'd2, 32'd3, 32'd255);
    feed(32'd1, 32'd2, 32'd3, 32'd255);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fb_if.mem_we === 1'b1 && !held) begin
        held = 1'b1;
        h_addr = fb_if.mem_addr;
        h_data = fb_if.mem_wdata;
      end else if (held && (fb_if.mem_we !== 1'b1 || fb_if.mem_addr !== h_addr || fb_if.mem_wdata !== h_data)) begin
        unstable++;
      end
    end
    // Two bursts fill the FIFO plus output register; a third does not fit.
    checks++;
    if (sd_pulses - sd0 !== 2) begin errors++; $display("FAIL backpressure_bursts: got %0d want 2", sd_pulses - sd0); end
    checks++;
    if (!held || unstable !== 0) begin errors++; $display("FAIL backpressure_stable: got held=%b changes=%0d want held=1 changes=0", held, unstable); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL backpressure_overflow: got %b want 0", overflow); end
    checks++;
    if (wr_addr.size() !== base) begin errors++; $display("FAIL backpressure_no_write: got %0d writes want 0", wr_addr.size() - base); end
    @(posedge clk);
    #1;
    fb_if.mem_busy = 1'b0;
    wait_writes(base + 12, "backpressure");
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (wr_addr[base+i] !== i || wr_data[base+i] !== EXP_B[i%4]) begin
        errors++;
        $display("FAIL backpressure_pix%0d: got addr=%0d data=%06h want addr=%0d data=%06h",
                 i, wr_addr[base+i], wr_data[base+i], i, EXP_B[i%4]);
      end
    end
    checks++;
    if (sd_pulses - sd0 !== 3) begin errors++; $display("FAIL backpressure_total_bursts: got %0d want 3", sd_pulses - sd0); end
    $display("backpressure: %0d pixels written after release", wr_addr.size() - base);
  endtask

  task automatic test_frame_pending();
    int base = wr_addr.size();
    int fd0  = fd_pulses;
    int cf0  = cf_pulses;
    int rise_cyc;
    frame_ready = 1'b0;
    feed(32'd1, 32'd2, 32'd3, 32'd255);
    wait_writes(base + 4, "frame_pending");
    tick(4);
    checks++;
    if (wr_addr[base+3] !== 15 || fd_pulses - fd0 !== 1) begin
      errors++;
      $display("FAIL pending_done: got last_addr=%0d pulses=%0d want last_addr=15 pulses=1", wr_addr[base+3], fd_pulses - fd0);
    end
    checks++;
    if (cf_pulses !== cf0) begin errors++; $display("FAIL pending_early_clear: got %0d pulses want 0", cf_pulses - cf0); end
    frame_ready = 1'b1;
    rise_cyc = cyc;
    tick(4);
    checks++;
    if (cf_pulses - cf0 !== 1 || cf_last_cyc !== rise_cyc) begin
      errors++;
      $display("FAIL pending_clear: got pulses=%0d at cyc %0d want 1 at cyc %0d", cf_pulses - cf0, cf_last_cyc, rise_cyc);
    end
    $display("frame_pending: clear_frame cyc=%0d", cf_last_cyc);
  endtask

  task automatic test_flush();
    int base = wr_addr.size();
    int fd0  = fd_pulses;
    int t    = 0;
    feed(32'd9, 32'd9, 32'd9, 32'd9);
    while (send_data !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (send_data !== 1'b1) begin errors++; $display("FAIL flush_request_timeout: got send_data=%b want 1", send_data); end
    // Cycle after REQ is k=0, the one after that is k=1.
    @(posedge clk);
    @(posedge clk);
    #1;
    render_reset = 1'b1;
    eng_words.delete();
    @(posedge clk);
    #1;
    render_reset = 1'b0;
    checks++;
    if (fb_if.mem_we !== 1'b0 || send_data !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_outputs: got we=%b sd=%b ovf=%b want 0 0 0", fb_if.mem_we, send_data, overflow);
    end
    tick(6);
    checks++;
    if (wr_addr.size() !== base || fb_if.mem_we !== 1'b0 || fd_pulses !== fd0) begin
      errors++;
      $display("FAIL flush_fifo_empty: got writes=%0d we=%b fd=%0d want 0 0 0", wr_addr.size() - base, fb_if.mem_we, fd_pulses - fd0);
    end
    feed(32'd1, 32'd2, 32'd3, 32'd255);
    wait_writes(base + 4, "flush_restart");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[base+i] !== i || wr_data[base+i] !== EXP_B[i]) begin
        errors++;
        $display("FAIL flush_restart_pix%0d: got addr=%0d data=%06h want addr=%0d data=%06h",
                 i, wr_addr[base+i], wr_data[base+i], i, EXP_B[i]);
      end
      $display("flush_restart: addr=%0d data=%06h", wr_addr[base+i], wr_data[base+i]);
    end
  endtask

  task automatic test_async_reset();
    int t = 0;
    int base;
    fb_if.mem_busy = 1'b1;
    feed(32'd7, 32'd7, 32'd7, 32'd7);
    while (fb_if.mem_we !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (fb_if.mem_we !== 1'b1 || fb_if.mem_addr !== 21'd4) begin
      errors++;
      $display("FAIL async_setup: got we=%b addr=%0d want we=1 addr=4", fb_if.mem_we, fb_if.mem_addr);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fb_if.mem_we !== 1'b0 || fb_if.mem_addr !== '0 || fb_if.mem_wdata !== 24'h0) begin
      errors++;
      $display("FAIL async_reset_bus: got we=%b addr=%0d data=%06h want 0 0 000000", fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata);
    end
    checks++;
    if (send_data !== 1'b0 || frame_done !== 1'b0 || clear_frame !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_flags: got sd=%b fd=%b cf=%b ovf=%b want 0", send_data, frame_done, clear_frame, overflow);
    end
    $display("async_reset: outputs cleared at t=%0t", $time);
    eng_words.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fb_if.mem_busy = 1'b0;
    base = wr_addr.size();
    tick(8);
    checks++;
    if (wr_addr.size() !== base || fb_if.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_empty: got writes=%0d we=%b want 0 0", wr_addr.size() - base, fb_if.mem_we);
    end
  endtask

  initial begin : main
    test_reset();
    test_single_burst();
    test_burst_order();
    test_frame_wrap();
    test_backpressure();
    test_frame_pending();
    test_flush();
    test_async_reset();
    checks++;
    if (sd_consec !== 0) begin errors++; $display("FAIL send_data_back_to_back: got %0d occurrences want 0", sd_consec); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
